// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage producer for the IF/ID register. Holds the PC, issues
// one instruction-memory read at a time, and presents {instr, pc, pc+4, code}
// from a single registered output entry. Branch and trap redirects flush the
// entry, and a misaligned PC or an access fault halts fetch until a trap arrives.
module fetch_unit #(
  parameter int unsigned                     XLEN     = 2,  // width code, 2 = 64-bit
  parameter logic [(1 << (XLEN + 4)) - 1:0]  RESET_PC = '0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clk_en,
  input  logic                              i_stall,
  input  logic                              i_redirect_valid,
  input  logic [(1 << (XLEN + 4)) - 1:0]    i_redirect_pc,
  input  logic                              i_trap_valid,
  input  logic [(1 << (XLEN + 4)) - 1:0]    i_trap_pc,
  output logic                              o_imem_req,
  output logic [(1 << (XLEN + 4)) - 1:0]    o_imem_addr,
  input  logic                              i_imem_ready,
  input  logic                              i_imem_rvalid,
  input  logic [31:0]                       i_imem_rdata,
  input  logic                              i_imem_err,
  output logic [31:0]                       o_instr_f,
  output logic [(1 << (XLEN + 4)) - 1:0]    o_pc_f,
  output logic [(1 << (XLEN + 4)) - 1:0]    o_pc_p4_f,
  output logic [3:0]                        o_exception_code_f,
  output logic                              o_exception_f_stall
);

  localparam int W = 1 << (XLEN + 4);
  localparam logic [W-1:0] PC_STEP = W'(4);

  // Exception codes shared with the rest of the pipeline
  localparam logic [3:0] NO_E               = 4'hF;
  localparam logic [3:0] E_IADDR_MISALIGNED = 4'h0;
  localparam logic [3:0] E_IACCESS_FAULT    = 4'h1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] r_pc, r_pc_nxt;
  logic [W-1:0] r_req_pc, r_req_pc_nxt;
  logic         buf_valid, buf_valid_nxt;
  logic [31:0]  buf_instr, buf_instr_nxt;
  logic [W-1:0] buf_pc, buf_pc_nxt;
  logic [3:0]   buf_exc, buf_exc_nxt;

  logic         buf_space;
  logic         misaligned;
  logic         accept;
  logic         redirect;
  logic [W-1:0] redirect_target;

  // The entry frees up when it is empty or leaves this cycle; a branch redirect
  // is not honoured while halted, only a trap can restart fetch.
  assign buf_space       = !buf_valid || !i_stall;
  assign misaligned      = r_pc[1:0] != 2'b00;
  assign o_imem_req      = i_clk_en && !i_rst && (state == IDLE) && !misaligned && buf_space;
  assign o_imem_addr     = r_pc;
  assign accept          = o_imem_req && i_imem_ready;
  assign redirect        = i_trap_valid || (i_redirect_valid && (state != HALT));
  assign redirect_target = i_trap_valid ? i_trap_pc : i_redirect_pc;

  // Present the held entry, or an all-zero bubble when the entry is empty
  assign o_instr_f           = buf_valid ? buf_instr : 32'd0;
  assign o_pc_f              = buf_valid ? buf_pc : '0;
  assign o_pc_p4_f           = buf_valid ? (buf_pc + PC_STEP) : '0;
  assign o_exception_code_f  = buf_valid ? buf_exc : NO_E;
  assign o_exception_f_stall = (state == HALT) && !buf_valid;

  // Next-state, PC and output-entry update; a redirect overrides the normal flow
  always_comb begin
    state_nxt     = state;
    r_pc_nxt      = r_pc;
    r_req_pc_nxt  = r_req_pc;
    buf_valid_nxt = buf_valid;
    buf_instr_nxt = buf_instr;
    buf_pc_nxt    = buf_pc;
    buf_exc_nxt   = buf_exc;

    if (buf_valid && !i_stall) begin
      buf_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (misaligned) begin
          if (buf_space) begin
            buf_valid_nxt = 1'b1;
            buf_instr_nxt = 32'd0;
            buf_pc_nxt    = r_pc;
            buf_exc_nxt   = E_IADDR_MISALIGNED;
            state_nxt     = HALT;
          end
        end else if (accept) begin
          r_req_pc_nxt = r_pc;
          r_pc_nxt     = r_pc + PC_STEP;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          buf_valid_nxt = 1'b1;
          buf_pc_nxt    = r_req_pc;
          if (i_imem_err) begin
            buf_instr_nxt = 32'd0;
            buf_exc_nxt   = E_IACCESS_FAULT;
            state_nxt     = HALT;
          end else begin
            buf_instr_nxt = i_imem_rdata;
            buf_exc_nxt   = NO_E;
            state_nxt     = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase

    if (redirect) begin
      r_pc_nxt      = redirect_target;
      buf_valid_nxt = 1'b0;
      case (state)
        IDLE:    state_nxt = accept ? DRAIN : IDLE;
        WAIT:    state_nxt = i_imem_rvalid ? IDLE : DRAIN;
        DRAIN:   state_nxt = i_imem_rvalid ? IDLE : DRAIN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset wins, otherwise everything holds without clock enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      buf_valid <= 1'b0;
      buf_instr <= 32'd0;
      buf_pc    <= '0;
      buf_exc   <= NO_E;
    end else if (i_clk_en) begin
      state     <= state_nxt;
      r_pc      <= r_pc_nxt;
      r_req_pc  <= r_req_pc_nxt;
      buf_valid <= buf_valid_nxt;
      buf_instr <= buf_instr_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_exc   <= buf_exc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an
// expected-entry queue built from the fetch rules (sequential pc+4 stream,
// redirect targets, fault entries), with a behavioural instruction memory.
module tb_fetch_unit;

  localparam int W = 64;
  localparam logic [3:0] NO_E   = 4'hF;
  localparam logic [3:0] E_MIS  = 4'h0;
  localparam logic [3:0] E_ACC  = 4'h1;

  logic          i_clk = 1'b0;
  logic          i_rst, i_clk_en, i_stall;
  logic          i_redirect_valid, i_trap_valid;
  logic [W-1:0]  i_redirect_pc, i_trap_pc;
  logic          o_imem_req;
  logic [W-1:0]  o_imem_addr;
  logic          i_imem_ready;
  logic          i_imem_rvalid = 1'b0;
  logic [31:0]   i_imem_rdata  = 32'd0;
  logic          i_imem_err    = 1'b0;
  logic [31:0]   o_instr_f;
  logic [W-1:0]  o_pc_f, o_pc_p4_f;
  logic [3:0]    o_exception_code_f;
  logic          o_exception_f_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [3:0]  code;
  } entry_t;

  entry_t      exp_q[$];
  logic [63:0] next_pc;

  // Memory model controls and state
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  logic [63:0] err_addr = '1;
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = '0;
  logic        req_q    = 1'b0;
  logic [63:0] addr_q   = '0;
  int          lat;

  fetch_unit #(.XLEN(2), .RESET_PC(64'h1000)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_clk_en            (i_clk_en),
    .i_stall             (i_stall),
    .i_redirect_valid    (i_redirect_valid),
    .i_redirect_pc       (i_redirect_pc),
    .i_trap_valid        (i_trap_valid),
    .i_trap_pc           (i_trap_pc),
    .o_imem_req          (o_imem_req),
    .o_imem_addr         (o_imem_addr),
    .i_imem_ready        (i_imem_ready),
    .i_imem_rvalid       (i_imem_rvalid),
    .i_imem_rdata        (i_imem_rdata),
    .i_imem_err          (i_imem_err),
    .o_instr_f           (o_instr_f),
    .o_pc_f              (o_pc_f),
    .o_pc_p4_f           (o_pc_p4_f),
    .o_exception_code_f  (o_exception_code_f),
    .o_exception_f_stall (o_exception_f_stall)
  );

  always #5 i_clk = ~i_clk;

  // Capture the request handshake just before the rising edge
  always @(negedge i_clk) begin
    #4;
    req_q  = o_imem_req && i_imem_ready;
    addr_q = o_imem_addr;
  end

  // Instruction memory: returns the address as data after 1..3 cycles
  always @(posedge i_clk) begin
    i_imem_rvalid <= 1'b0;
    if (i_rst) begin
      mem_pend <= 1'b0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          i_imem_rvalid <= 1'b1;
          i_imem_rdata  <= mem_addr[31:0];
          i_imem_err    <= (mem_addr == err_addr);
          mem_pend      <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (req_q) begin
        lat = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        if (lat == 1) begin
          i_imem_rvalid <= 1'b1;
          i_imem_rdata  <= addr_q[31:0];
          i_imem_err    <= (addr_q == err_addr);
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= lat - 1;
          mem_addr <= addr_q;
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic entry_t mkEntry(input logic [63:0] pc, input logic [3:0] code);
    entry_t e;
    e.pc    = pc;
    e.instr = (code == NO_E) ? pc[31:0] : 32'd0;
    e.code  = code;
    return e;
  endfunction

  function automatic bit outValid();
    return (o_pc_f != '0) || (o_pc_p4_f != '0) || (o_instr_f != 32'd0) || (o_exception_code_f != NO_E);
  endfunction

  task automatic pushSeq(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mkEntry(next_pc, NO_E));
      next_pc = next_pc + 64'd4;
    end
  endtask

  // One-cycle redirect/trap pulse driven from a falling edge
  task automatic applyStimulus(input logic trap, input logic [63:0] tpc,
                               input logic redir, input logic [63:0] rpc);
    i_trap_valid     = trap;
    i_trap_pc        = tpc;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    @(negedge i_clk);
    i_trap_valid     = 1'b0;
    i_redirect_valid = 1'b0;
  endtask

  // Consume n entries and compare each against the expected queue
  task automatic runStream(input int n, input bit rnd, input int budget);
    int     got = 0;
    int     cyc = 0;
    entry_t e;
    while (got < n && cyc < budget) begin
      if (rnd) begin
        i_stall      = ($urandom_range(0, 3) == 0);
        i_imem_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_stall      = 1'b0;
        i_imem_ready = 1'b1;
      end
      if (outValid() && !i_stall && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_f", o_pc_f, e.pc);
        checkOutput("instr_f", 64'(o_instr_f), 64'(e.instr));
        checkOutput("pc_p4_f", o_pc_p4_f, e.pc + 64'd4);
        checkOutput("code_f", 64'(o_exception_code_f), 64'(e.code));
        got++;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_stall      = 1'b0;
    i_imem_ready = 1'b1;
    checkOutput("stream_count", 64'(got), 64'(n));
  endtask

  initial begin
    int   k;
    logic req_seen;
    logic [63:0] held;

    i_rst = 1'b1; i_clk_en = 1'b1; i_stall = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_pc = '0;
    i_trap_valid = 1'b0; i_trap_pc = '0;
    i_imem_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge i_clk);
    checkOutput("rst_req", 64'(o_imem_req), 64'd0);
    checkOutput("rst_pc", o_pc_f, 64'd0);
    checkOutput("rst_instr", 64'(o_instr_f), 64'd0);
    checkOutput("rst_p4", o_pc_p4_f, 64'd0);
    checkOutput("rst_code", 64'(o_exception_code_f), 64'(NO_E));
    checkOutput("rst_xstall", 64'(o_exception_f_stall), 64'd0);

    // First fetch from the reset PC, two-cycle latency, then in-order stream
    i_rst = 1'b0;
    #1;
    checkOutput("first_req", 64'(o_imem_req), 64'd1);
    checkOutput("first_addr", o_imem_addr, 64'h1000);
    @(negedge i_clk);
    checkOutput("first_bubble", o_pc_f, 64'd0);
    @(negedge i_clk);
    checkOutput("latency_pc", o_pc_f, 64'h1000);
    next_pc = 64'h1000;
    pushSeq(3);
    runStream(3, 1'b0, 30);

    // Stall with a valid entry: held outputs, no further requests
    i_stall = 1'b1;
    k = 0;
    while (!outValid() && k < 10) begin @(negedge i_clk); k++; end
    checkOutput("stall_entry", o_pc_f, next_pc);
    held = o_pc_f;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checkOutput("stall_hold", o_pc_f, held);
      if (c > 0) checkOutput("stall_noreq", 64'(o_imem_req), 64'd0);
    end
    pushSeq(3);
    runStream(3, 1'b0, 30);

    // Redirect while a slow response is outstanding
    mem_lat = 3;
    k = 0;
    while (!o_imem_req && k < 20) begin @(negedge i_clk); k++; end
    checkOutput("wait_req_seen", 64'(o_imem_req), 64'd1);
    @(negedge i_clk);
    applyStimulus(1'b0, 64'd0, 1'b1, 64'h2000);
    checkOutput("redir_bubble", o_pc_f, 64'd0);
    exp_q.delete();
    next_pc = 64'h2000;
    pushSeq(3);
    runStream(3, 1'b0, 40);
    mem_lat = 1;

    // Trap beats branch redirect in the same cycle
    applyStimulus(1'b1, 64'h80, 1'b1, 64'h2000);
    checkOutput("trap_bubble", o_pc_f, 64'd0);
    exp_q.delete();
    next_pc = 64'h80;
    pushSeq(2);
    runStream(2, 1'b0, 30);

    // Misaligned redirect target faults without a request
    applyStimulus(1'b0, 64'd0, 1'b1, 64'h2002);
    i_stall  = 1'b1;
    req_seen = o_imem_req;
    k = 0;
    while (o_exception_code_f == NO_E && k < 10) begin
      @(negedge i_clk);
      req_seen = req_seen | o_imem_req;
      k++;
    end
    checkOutput("mis_code", 64'(o_exception_code_f), 64'(E_MIS));
    checkOutput("mis_pc", o_pc_f, 64'h2002);
    checkOutput("mis_instr", 64'(o_instr_f), 64'd0);
    checkOutput("mis_p4", o_pc_p4_f, 64'h2006);
    checkOutput("mis_noreq", 64'(req_seen), 64'd0);
    checkOutput("mis_xstall_pre", 64'(o_exception_f_stall), 64'd0);
    i_stall = 1'b0;
    @(negedge i_clk);
    checkOutput("mis_xstall", 64'(o_exception_f_stall), 64'd1);
    checkOutput("halt_noreq", 64'(o_imem_req), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 64'h3000);
    checkOutput("halt_ignores_redir", 64'(o_exception_f_stall), 64'd1);
    applyStimulus(1'b1, 64'h80, 1'b0, 64'd0);
    checkOutput("trap_release", 64'(o_exception_f_stall), 64'd0);
    exp_q.delete();
    next_pc = 64'h80;
    pushSeq(2);
    runStream(2, 1'b0, 30);

    // Access fault on the second fetch after a fresh reset
    i_rst = 1'b1;
    err_addr = 64'h1004;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(mkEntry(64'h1000, NO_E));
    exp_q.push_back(mkEntry(64'h1004, E_ACC));
    runStream(2, 1'b0, 30);
    checkOutput("acc_xstall", 64'(o_exception_f_stall), 64'd1);
    checkOutput("acc_noreq", 64'(o_imem_req), 64'd0);

    // PC wrap from the top of the address space
    err_addr = '1;
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0);
    exp_q.delete();
    next_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    pushSeq(3);
    runStream(3, 1'b0, 30);

    // Randomized stall, ready and memory latency on the sequential stream
    mem_rand = 1'b1;
    pushSeq(30);
    runStream(30, 1'b1, 800);
    mem_rand = 1'b0;

    // Clock enable low freezes everything even without a stall
    i_stall = 1'b1;
    k = 0;
    while (!outValid() && k < 20) begin @(negedge i_clk); k++; end
    checkOutput("ce_entry", o_pc_f, next_pc);
    i_clk_en = 1'b0;
    i_stall  = 1'b0;
    #1;
    checkOutput("ce_noreq", 64'(o_imem_req), 64'd0);
    repeat (2) @(negedge i_clk);
    checkOutput("ce_hold", o_pc_f, next_pc);
    i_clk_en = 1'b1;
    pushSeq(3);
    runStream(3, 1'b0, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
